// File: rtl/pdp_mem_responder_if.sv
// Bus bundle for the PDP memory responder: two read ports, one execute write
// port, a preload port, and the status/statistics outputs.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

interface pdp_mem_responder_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_WIDTH  = 32
);
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  exec_rd_req;
  logic [ADDR_WIDTH-1:0] exec_rd_addr;
  logic [DATA_WIDTH-1:0] exec_rd_data;
  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;
  logic                  ld_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  uninit_rd;
  logic                  wr_drop;
  logic [CNT_WIDTH-1:0]  rd_cnt;
  logic [CNT_WIDTH-1:0]  wr_cnt;

  modport master (
    output ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr,
    output exec_wr_req, exec_wr_addr, exec_wr_data, ld_en, ld_addr, ld_data,
    input  ifu_rd_data, exec_rd_data, uninit_rd, wr_drop, rd_cnt, wr_cnt
  );

  modport slave (
    input  ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_rd_addr,
    input  exec_wr_req, exec_wr_addr, exec_wr_data, ld_en, ld_addr, ld_data,
    output ifu_rd_data, exec_rd_data, uninit_rd, wr_drop, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/pdp_mem_responder.sv
// Dual-read, single-write PDP word memory with preload port, per-word
// written-valid tracking, write-first bypass and saturating statistics.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp_mem_responder #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input logic           clk,
  input logic           reset_n,
  pdp_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]      valid_r;
  logic [DATA_WIDTH-1:0] ifu_rd_data_r, exec_rd_data_r;
  logic                  uninit_rd_r, wr_drop_r;
  logic [CNT_WIDTH-1:0]  rd_cnt_r, wr_cnt_r;

  logic                  ld_s, wr_collide_s, ex_wr_s;
  logic [DATA_WIDTH:0]   ifu_look_s, exec_look_s;
  logic [1:0]            rd_inc_s;
  logic [CNT_WIDTH:0]    rd_sum_s, wr_sum_s;
  logic [CNT_WIDTH-1:0]  rd_cnt_nxt_s, wr_cnt_nxt_s;

  // Returns {uninit, data}; same-cycle writes bypass the array (preload first,
  // since it wins any collision), otherwise an unwritten word reads as zero.
  function automatic logic [DATA_WIDTH:0] lookup(
    input logic [ADDR_WIDTH-1:0] raddr,
    input logic                  ld, input logic [ADDR_WIDTH-1:0] laddr,
    input logic [DATA_WIDTH-1:0] ldata,
    input logic                  wr, input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic                  vbit, input logic [DATA_WIDTH-1:0] word
  );
    logic [DATA_WIDTH:0] res;
    if (ld && (laddr == raddr)) begin
      res = {1'b0, ldata};
    end else if (wr && (waddr == raddr)) begin
      res = {1'b0, wdata};
    end else if (vbit) begin
      res = {1'b0, word};
    end else begin
      res = {1'b1, {DATA_WIDTH{1'b0}}};
    end
    return res;
  endfunction

  // Write qualification and collision detection.
  always_comb begin
    ld_s         = bus.ld_en & reset_n;
    wr_collide_s = bus.ld_en & bus.exec_wr_req & (bus.ld_addr == bus.exec_wr_addr);
    ex_wr_s      = bus.exec_wr_req & reset_n & ~wr_collide_s;
  end

  // Per-port read lookup with bypass.
  always_comb begin
    ifu_look_s  = lookup(bus.ifu_rd_addr, ld_s, bus.ld_addr, bus.ld_data,
                         ex_wr_s, bus.exec_wr_addr, bus.exec_wr_data,
                         valid_r[bus.ifu_rd_addr], mem_r[bus.ifu_rd_addr]);
    exec_look_s = lookup(bus.exec_rd_addr, ld_s, bus.ld_addr, bus.ld_data,
                         ex_wr_s, bus.exec_wr_addr, bus.exec_wr_data,
                         valid_r[bus.exec_rd_addr], mem_r[bus.exec_rd_addr]);
  end

  // Saturating next-count for both statistics counters.
  always_comb begin
    rd_inc_s = {1'b0, bus.ifu_rd_req} + {1'b0, bus.exec_rd_req};
    rd_sum_s = {1'b0, rd_cnt_r} + {{(CNT_WIDTH-1){1'b0}}, rd_inc_s};
    wr_sum_s = {1'b0, wr_cnt_r} + {{CNT_WIDTH{1'b0}}, ex_wr_s};
    if (rd_sum_s[CNT_WIDTH]) begin
      rd_cnt_nxt_s = {CNT_WIDTH{1'b1}};
    end else begin
      rd_cnt_nxt_s = rd_sum_s[CNT_WIDTH-1:0];
    end
    if (wr_sum_s[CNT_WIDTH]) begin
      wr_cnt_nxt_s = {CNT_WIDTH{1'b1}};
    end else begin
      wr_cnt_nxt_s = wr_sum_s[CNT_WIDTH-1:0];
    end
  end

  // Output registers, valid bits and counters; requests ignored under reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ifu_rd_data_r  <= {DATA_WIDTH{1'b0}};
      exec_rd_data_r <= {DATA_WIDTH{1'b0}};
      uninit_rd_r    <= 1'b0;
      wr_drop_r      <= 1'b0;
      rd_cnt_r       <= {CNT_WIDTH{1'b0}};
      wr_cnt_r       <= {CNT_WIDTH{1'b0}};
      valid_r        <= {DEPTH{1'b0}};
    end else begin
      if (bus.ifu_rd_req) begin
        ifu_rd_data_r <= ifu_look_s[DATA_WIDTH-1:0];
      end
      if (bus.exec_rd_req) begin
        exec_rd_data_r <= exec_look_s[DATA_WIDTH-1:0];
      end
      uninit_rd_r <= (bus.ifu_rd_req & ifu_look_s[DATA_WIDTH]) |
                     (bus.exec_rd_req & exec_look_s[DATA_WIDTH]);
      wr_drop_r   <= wr_collide_s;
      rd_cnt_r    <= rd_cnt_nxt_s;
      wr_cnt_r    <= wr_cnt_nxt_s;
      if (ex_wr_s) begin
        valid_r[bus.exec_wr_addr] <= 1'b1;
      end
      if (ld_s) begin
        valid_r[bus.ld_addr] <= 1'b1;
      end
    end
  end

  // Word array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ex_wr_s) begin
      mem_r[bus.exec_wr_addr] <= bus.exec_wr_data;
    end
    if (ld_s) begin
      mem_r[bus.ld_addr] <= bus.ld_data;
    end
  end

  assign bus.ifu_rd_data  = ifu_rd_data_r;
  assign bus.exec_rd_data = exec_rd_data_r;
  assign bus.uninit_rd    = uninit_rd_r;
  assign bus.wr_drop      = wr_drop_r;
  assign bus.rd_cnt       = rd_cnt_r;
  assign bus.wr_cnt       = wr_cnt_r;
endmodule

// File: tb/tb_pdp_mem_responder.sv
// Scoreboard bench for pdp_mem_responder: a behavioural model predicts each
// cycle's outputs, which are queued and compared one edge later.
module tb_pdp_mem_responder;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  pdp_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  pdp_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] ifu;
    logic [DW-1:0] ex;
    logic          un;
    logic          drop;
    logic [CW-1:0] rc;
    logic [CW-1:0] wc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_mem [1 << AW];
  bit            m_val [1 << AW];
  logic [DW-1:0] m_ifu, m_ex;
  int            m_rc, m_wc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic idle();
    bus.ifu_rd_req   = 1'b0; bus.ifu_rd_addr  = '0;
    bus.exec_rd_req  = 1'b0; bus.exec_rd_addr = '0;
    bus.exec_wr_req  = 1'b0; bus.exec_wr_addr = '0; bus.exec_wr_data = '0;
    bus.ld_en        = 1'b0; bus.ld_addr      = '0; bus.ld_data      = '0;
  endtask

  function automatic logic [DW:0] m_read(input logic [AW-1:0] a);
    if (bus.ld_en && bus.ld_addr == a) return {1'b0, bus.ld_data};
    if (bus.exec_wr_req && bus.exec_wr_addr == a) return {1'b0, bus.exec_wr_data};
    if (m_val[a]) return {1'b0, m_mem[a]};
    return {1'b1, {DW{1'b0}}};
  endfunction

  // Predict, clock once, then compare the popped prediction with the DUT.
  task automatic step();
    exp_t e, g;
    logic [DW:0] ri, re;
    bit   drop;
    if (!reset_n) begin
      foreach (m_val[i]) m_val[i] = 1'b0;
      m_ifu = '0; m_ex = '0; m_rc = 0; m_wc = 0;
      e.un = 1'b0; e.drop = 1'b0;
    end else begin
      ri = m_read(bus.ifu_rd_addr);
      re = m_read(bus.exec_rd_addr);
      if (bus.ifu_rd_req)  m_ifu = ri[DW-1:0];
      if (bus.exec_rd_req) m_ex  = re[DW-1:0];
      e.un = (bus.ifu_rd_req && ri[DW]) || (bus.exec_rd_req && re[DW]);
      drop = bus.ld_en && bus.exec_wr_req && (bus.ld_addr == bus.exec_wr_addr);
      e.drop = drop;
      m_rc = m_rc + int'(bus.ifu_rd_req) + int'(bus.exec_rd_req);
      if (m_rc > 15) m_rc = 15;
      if (bus.exec_wr_req && !drop) begin
        m_mem[bus.exec_wr_addr] = bus.exec_wr_data;
        m_val[bus.exec_wr_addr] = 1'b1;
        m_wc = (m_wc < 15) ? m_wc + 1 : 15;
      end
      if (bus.ld_en) begin
        m_mem[bus.ld_addr] = bus.ld_data;
        m_val[bus.ld_addr] = 1'b1;
      end
    end
    e.ifu = m_ifu; e.ex = m_ex; e.rc = CW'(m_rc); e.wc = CW'(m_wc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("ifu_data",  bus.ifu_rd_data,  g.ifu);
    chk("exec_data", bus.exec_rd_data, g.ex);
    chk("uninit",    bus.uninit_rd,    g.un);
    chk("wr_drop",   bus.wr_drop,      g.drop);
    chk("rd_cnt",    bus.rd_cnt,       g.rc);
    chk("wr_cnt",    bus.wr_cnt,       g.wc);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    // Reset with requests and a preload present: all must be ignored.
    reset_n = 1'b0;
    bus.ifu_rd_req = 1'b1; bus.exec_rd_req = 1'b1; bus.exec_wr_req = 1'b1;
    bus.exec_wr_addr = 12'o400; bus.exec_wr_data = 12'o4444;
    bus.ld_en = 1'b1; bus.ld_addr = 12'o500; bus.ld_data = 12'o5050;
    step();
    step();
    chk("rst_rd_cnt", bus.rd_cnt, 32'd0);
    chk("rst_ifu", bus.ifu_rd_data, 32'd0);
    reset_n = 1'b1;
    idle();
    bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o500;
    step();
    chk("rst_ld_ignored_un", bus.uninit_rd, 32'd1);

    // Preload then fetch.
    idle(); bus.ld_en = 1'b1; bus.ld_addr = 12'o200; bus.ld_data = 12'o7001;
    step();
    idle(); bus.ifu_rd_req = 1'b1; bus.ifu_rd_addr = 12'o200;
    step();
    chk("r037_data", bus.ifu_rd_data, 32'o7001);
    chk("r037_un", bus.uninit_rd, 32'd0);

    // Write-first bypass on exec port.
    idle(); bus.exec_wr_req = 1'b1; bus.exec_wr_addr = 12'o300; bus.exec_wr_data = 12'o1234;
    bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o300;
    step();
    chk("r038_data", bus.exec_rd_data, 32'o1234);
    chk("r038_wc", bus.wr_cnt, 32'd1);
    idle(); step();
    chk("hold_ifu", bus.ifu_rd_data, 32'o7001);

    // Unwritten top address after reset.
    do_reset();
    idle(); bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o7777;
    step();
    chk("r039_data", bus.exec_rd_data, 32'd0);
    chk("r039_un", bus.uninit_rd, 32'd1);
    chk("r039_rc", bus.rd_cnt, 32'd1);
    idle(); step();
    chk("r039_un_once", bus.uninit_rd, 32'd0);

    // Preload / exec collision.
    idle(); bus.ld_en = 1'b1; bus.ld_addr = 12'o10; bus.ld_data = 12'o5555;
    bus.exec_wr_req = 1'b1; bus.exec_wr_addr = 12'o10; bus.exec_wr_data = 12'o2222;
    step();
    chk("r040_drop", bus.wr_drop, 32'd1);
    chk("r040_wc", bus.wr_cnt, 32'd0);
    idle(); bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o10;
    step();
    chk("r040_word", bus.exec_rd_data, 32'o5555);
    chk("r040_drop_once", bus.wr_drop, 32'd0);

    // Dual read of preloaded words, then different-address ld+exec.
    do_reset();
    idle(); bus.ld_en = 1'b1; bus.ld_addr = 12'o0; bus.ld_data = 12'o11;
    bus.exec_wr_req = 1'b1; bus.exec_wr_addr = 12'o7777; bus.exec_wr_data = 12'o6543;
    step();
    chk("r028_wc", bus.wr_cnt, 32'd1);
    idle(); bus.ld_en = 1'b1; bus.ld_addr = 12'o1; bus.ld_data = 12'o22;
    step();
    idle(); bus.ifu_rd_req = 1'b1; bus.ifu_rd_addr = 12'o0;
    bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o1;
    step();
    chk("r041_ifu", bus.ifu_rd_data, 32'o11);
    chk("r041_ex", bus.exec_rd_data, 32'o22);
    chk("r041_rc", bus.rd_cnt, 32'd2);
    idle(); bus.ifu_rd_req = 1'b1; bus.ifu_rd_addr = 12'o7777;
    step();
    chk("top_addr", bus.ifu_rd_data, 32'o6543);

    // Reset asserted while a read is presented.
    idle(); bus.ifu_rd_req = 1'b1; bus.ifu_rd_addr = 12'o1;
    reset_n = 1'b0;
    step();
    chk("mid_rst_ifu", bus.ifu_rd_data, 32'd0);
    reset_n = 1'b1;

    // Random traffic over a small address set including both ends.
    for (int i = 0; i < 200; i++) begin
      logic [AW-1:0] pick [6];
      pick[0] = 12'o0; pick[1] = 12'o1; pick[2] = 12'o2;
      pick[3] = 12'o3; pick[4] = 12'o7776; pick[5] = 12'o7777;
      bus.ifu_rd_req   = 1'($urandom_range(1));
      bus.ifu_rd_addr  = pick[$urandom_range(5)];
      bus.exec_rd_req  = 1'($urandom_range(1));
      bus.exec_rd_addr = pick[$urandom_range(5)];
      bus.exec_wr_req  = 1'($urandom_range(1));
      bus.exec_wr_addr = pick[$urandom_range(5)];
      bus.exec_wr_data = DW'($urandom);
      bus.ld_en        = ($urandom_range(3) == 0);
      bus.ld_addr      = pick[$urandom_range(5)];
      bus.ld_data      = DW'($urandom);
      if (i % 50 == 49) reset_n = 1'b0;
      step();
      reset_n = 1'b1;
    end

    // Saturation of both counters.
    do_reset();
    idle(); bus.ifu_rd_req = 1'b1; bus.exec_rd_req = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("r042_pre", bus.rd_cnt, 32'd14);
    step();
    chk("r042_sat", bus.rd_cnt, 32'd15);
    step(); step();
    chk("r042_hold", bus.rd_cnt, 32'd15);
    idle(); bus.exec_wr_req = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.exec_wr_addr = AW'(i);
      step();
    end
    chk("wc_sat", bus.wr_cnt, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
